// File: rtl/deserializador_pkg.sv
// Shared definitions for the serial-to-parallel receiver with output FIFO.
// Holds the receiver FSM state type and the default word width and FIFO depth.
package deserializador_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef enum logic {
        StIdle   = 1'b0,
        StRecebe = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous active-low reset (empties the FIFO, clears head)
//   push   - write wdata (ignored when full)
//   pop    - drop the head word (ignored when empty)
//   wdata  - word to write
//   full   - count == DEPTH
//   empty  - count == 0
//   count  - words currently stored
//   head   - oldest word; holds its last value once the FIFO drains
module fifo_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_q;
    assign head    = head_q;

    always_comb begin
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
        // Head is registered so it can hold its value after the last pop.
        // When the new head slot is the one being written this edge, forward wdata.
        head_d = head_q;
        if (count_d != '0) begin
            head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? wdata : mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/deserializador_fifo.sv
// Serial-to-parallel receiver feeding an output FIFO.
// Bits arrive one per cycle on data_in while write_in is high; each WIDTH bits form a word
// that is pushed into a first-word-fall-through FIFO for the consumer.
// Ports:
//   clock_100KHz - sole clock
//   reset        - synchronous active-low reset
//   data_in      - serial bit, sampled when write_in=1
//   write_in     - bit-valid strobe
//   ack_in       - pop request for the FIFO head word
//   data_out     - FIFO head word
//   data_ready   - FIFO not empty
//   status_out   - FIFO full; sender must hold write_in low
//   count_out    - words stored in the FIFO
//   abort_out    - one-cycle pulse when a partial word is discarded
//   overflow_out - sticky flag: a bit was offered while full
module deserializador_fifo
    import deserializador_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                       clock_100KHz,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       ack_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_ready,
    output logic                       status_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       abort_out,
    output logic                       overflow_out
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_next;
    logic [CW-1:0]    bit_idx;
    logic             abort_q, overflow_q;
    logic             full, empty;
    logic             accept, last_bit, push;

    assign status_out   = full;
    assign data_ready   = ~empty;
    assign abort_out    = abort_q;
    assign overflow_out = overflow_q;

    always_comb begin
        accept    = write_in & ~full;
        last_bit  = (bit_cnt_q == LAST);
        push      = accept & last_bit;
        bit_idx   = MSB_FIRST ? (LAST - bit_cnt_q) : bit_cnt_q;
        word_next = word_q;
        word_next[bit_idx] = data_in;
    end

    always_ff @(posedge clock_100KHz) begin
        if (!reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            word_q     <= '0;
            abort_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            if (write_in && full) begin
                overflow_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    // WIDTH >= 2, so the first bit never completes a word.
                    if (accept) begin
                        word_q    <= word_next;
                        bit_cnt_q <= CW'(1);
                        state_q   <= StRecebe;
                    end
                end
                StRecebe: begin
                    if (accept) begin
                        if (last_bit) begin
                            word_q    <= '0;
                            bit_cnt_q <= '0;
                            state_q   <= StIdle;
                        end else begin
                            word_q    <= word_next;
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end else if (!write_in) begin
                        // Counter is always nonzero here, so a dropped strobe is an abort.
                        word_q    <= '0;
                        bit_cnt_q <= '0;
                        abort_q   <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clock_100KHz),
        .reset (reset),
        .push  (push),
        .pop   (ack_in),
        .wdata (word_next),
        .full  (full),
        .empty (empty),
        .count (count_out),
        .head  (data_out)
    );

endmodule

// File: tb/tb_deserializador_fifo.sv
module tb_deserializador_fifo;

    logic       clk = 1'b0;
    logic       reset, data_in, write_in, ack_in;
    logic [7:0] data_out, data_out_m;
    logic       data_ready, data_ready_m, status_out, status_out_m;
    logic [2:0] count_out, count_out_m;
    logic       abort_out, abort_out_m, overflow_out, overflow_out_m;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    deserializador_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut (
        .clock_100KHz (clk),
        .reset        (reset),
        .data_in      (data_in),
        .write_in     (write_in),
        .ack_in       (ack_in),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .status_out   (status_out),
        .count_out    (count_out),
        .abort_out    (abort_out),
        .overflow_out (overflow_out)
    );

    deserializador_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clock_100KHz (clk),
        .reset        (reset),
        .data_in      (data_in),
        .write_in     (write_in),
        .ack_in       (ack_in),
        .data_out     (data_out_m),
        .data_ready   (data_ready_m),
        .status_out   (status_out_m),
        .count_out    (count_out_m),
        .abort_out    (abort_out_m),
        .overflow_out (overflow_out_m)
    );

    // seq bit i is the i-th serial bit sent
    typedef struct {
        logic [7:0] seq;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input bit drop);
        for (int i = 0; i < 8; i++) begin
            data_in  = w[i];
            write_in = 1'b1;
            tick();
        end
        if (drop) begin
            write_in = 1'b0;
            data_in  = 1'b0;
        end
    endtask

    task automatic pop();
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] words [4];
        logic [7:0] w;

        reset = 1'b0; data_in = 1'b0; write_in = 1'b0; ack_in = 1'b0;
        repeat (2) tick();
        check("rst data_out",   {24'd0, data_out}, 32'h0);
        check("rst data_ready", {31'd0, data_ready}, 32'h0);
        check("rst status_out", {31'd0, status_out}, 32'h0);
        check("rst count_out",  {29'd0, count_out}, 32'h0);
        check("rst abort_out",  {31'd0, abort_out}, 32'h0);
        check("rst overflow",   {31'd0, overflow_out}, 32'h0);
        reset = 1'b1;

        vecs[0] = '{seq: 8'hA5, exp_lsb: 8'hA5, exp_msb: 8'hA5};
        vecs[1] = '{seq: 8'h03, exp_lsb: 8'h03, exp_msb: 8'hC0};
        vecs[2] = '{seq: 8'h01, exp_lsb: 8'h01, exp_msb: 8'h80};
        vecs[3] = '{seq: 8'hF1, exp_lsb: 8'hF1, exp_msb: 8'h8F};
        vecs[4] = '{seq: 8'h12, exp_lsb: 8'h12, exp_msb: 8'h48};
        vecs[5] = '{seq: 8'h3C, exp_lsb: 8'h3C, exp_msb: 8'h3C};

        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].seq, 1'b1);
            check("vec head lsb",  {24'd0, data_out}, {24'd0, vecs[i].exp_lsb});
            check("vec head msb",  {24'd0, data_out_m}, {24'd0, vecs[i].exp_msb});
            check("vec count",     {29'd0, count_out}, 32'd1);
            check("vec ready",     {31'd0, data_ready}, 32'd1);
            check("vec abort",     {31'd0, abort_out}, 32'd0);
            pop();
            check("vec pop count", {29'd0, count_out}, 32'd0);
            check("vec pop ready", {31'd0, data_ready}, 32'd0);
            check("vec pop hold",  {24'd0, data_out}, {24'd0, vecs[i].exp_lsb});
        end

        // Fill to DEPTH with write_in held high, then offer a fifth word
        do_reset();
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        for (int k = 0; k < 4; k++) send_word(words[k], 1'b0);
        check("full status",   {31'd0, status_out}, 32'd1);
        check("full count",    {29'd0, count_out}, 32'd4);
        check("full head",     {24'd0, data_out}, 32'h11);
        check("full ovf pre",  {31'd0, overflow_out}, 32'd0);
        send_word(8'h55, 1'b1);
        check("ovf flag",      {31'd0, overflow_out}, 32'd1);
        check("ovf count",     {29'd0, count_out}, 32'd4);
        check("ovf abort",     {31'd0, abort_out}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("drain order", {24'd0, data_out}, {24'd0, words[k]});
            pop();
        end
        check("drain count",   {29'd0, count_out}, 32'd0);
        check("drain status",  {31'd0, status_out}, 32'd0);
        check("drain hold",    {24'd0, data_out}, 32'h44);
        check("ovf sticky",    {31'd0, overflow_out}, 32'd1);

        // Partial word abort
        do_reset();
        check("rst clr ovf",   {31'd0, overflow_out}, 32'd0);
        send_word(8'h66, 1'b1);
        w = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            data_in = w[i]; write_in = 1'b1;
            tick();
        end
        write_in = 1'b0;
        tick();
        check("abort pulse",   {31'd0, abort_out}, 32'd1);
        check("abort count",   {29'd0, count_out}, 32'd1);
        tick();
        check("abort one cyc", {31'd0, abort_out}, 32'd0);
        send_word(8'h3C, 1'b1);
        check("post abort cnt", {29'd0, count_out}, 32'd2);
        check("post abort hd", {24'd0, data_out}, 32'h66);
        pop();
        check("post abort w",  {24'd0, data_out}, 32'h3C);

        // Push and pop on the same edge
        do_reset();
        send_word(8'h10, 1'b1);
        send_word(8'h20, 1'b1);
        w = 8'h77;
        for (int i = 0; i < 8; i++) begin
            data_in = w[i]; write_in = 1'b1; ack_in = (i == 7);
            tick();
        end
        write_in = 1'b0; ack_in = 1'b0;
        check("simul count",   {29'd0, count_out}, 32'd2);
        check("simul head",    {24'd0, data_out}, 32'h20);
        pop();
        check("simul last",    {24'd0, data_out}, 32'h77);
        check("simul cnt1",    {29'd0, count_out}, 32'd1);

        // Reset mid-word with three words stored, inputs active during reset
        do_reset();
        send_word(8'h01, 1'b1);
        send_word(8'h02, 1'b1);
        send_word(8'h03, 1'b1);
        check("pre rst count", {29'd0, count_out}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            data_in = 1'b1; write_in = 1'b1;
            tick();
        end
        reset = 1'b0; ack_in = 1'b1;
        tick();
        check("mid rst data",  {24'd0, data_out}, 32'h0);
        check("mid rst ready", {31'd0, data_ready}, 32'd0);
        check("mid rst count", {29'd0, count_out}, 32'd0);
        check("mid rst status", {31'd0, status_out}, 32'd0);
        check("mid rst abort", {31'd0, abort_out}, 32'd0);
        reset = 1'b1; write_in = 1'b0; ack_in = 1'b0; data_in = 1'b0;
        tick();
        check("mid rst no abort", {31'd0, abort_out}, 32'd0);
        send_word(8'h5A, 1'b1);
        check("after rst word", {24'd0, data_out}, 32'h5A);
        check("after rst cnt", {29'd0, count_out}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/deserializador_fifo.md
DESERIALIZADOR_FIFO -- requirements
Module: deserializador_fifo

Interface
REQ-001 Parameter WIDTH, default 8, word width in bits (2..32).
REQ-002 Parameter DEPTH, default 4, output FIFO depth in words (power of 2, 2..16).
REQ-003 Parameter MSB_FIRST, default 0: 0 = first serial bit lands in bit 0; 1 = first bit lands in bit WIDTH-1.
REQ-004 clock_100KHz  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 data_in  in  1  serial data bit, sampled when write_in=1.
REQ-007 write_in  in  1  bit-valid strobe; one bit per cycle while high.
REQ-008 ack_in  in  1  consumer pop request for the FIFO head word.
REQ-009 data_out  out  WIDTH  FIFO head word (first-word-fall-through).
REQ-010 data_ready  out  1  FIFO not empty.
REQ-011 status_out  out  1  FIFO full; sender must hold write_in low.
REQ-012 count_out  out  $clog2(DEPTH+1)  words currently stored.
REQ-013 abort_out  out  1  one-cycle pulse: partial word discarded.
REQ-014 overflow_out  out  1  sticky: a bit was offered while status_out=1.

Function
REQ-015 FSM states IDLE and RECEBE; IDLE -> RECEBE on first accepted bit; RECEBE -> IDLE on word completion or abort.
REQ-016 A bit is accepted on a rising edge where write_in=1 and status_out=0, including the first cycle of write_in (no idle wait cycle).
REQ-017 Bit counter runs 0..WIDTH-1; accepted bit stored at index count (MSB_FIRST=0) or WIDTH-1-count (MSB_FIRST=1).
REQ-018 On acceptance of bit WIDTH-1, the completed word is pushed to the FIFO on that same edge and the bit counter returns to 0.
REQ-019 Latency: with FIFO empty, data_ready=1 and data_out valid in the cycle after the edge accepting the last bit.
REQ-020 Back-to-back words allowed: write_in may stay high across word boundaries with no gap cycle.
REQ-021 write_in=0 in RECEBE with counter>0 discards the partial word, clears the counter, pulses abort_out for one cycle, returns to IDLE.
REQ-022 write_in=1 while status_out=1: bit ignored, partial word and counter held, overflow_out set to 1 until reset.
REQ-023 ack_in=1 with data_ready=1 pops the head; data_out shows the next word (or holds its value if emptied) the following cycle.
REQ-024 ack_in=1 with data_ready=0 is ignored.
REQ-025 Simultaneous push and pop: both occur, count_out unchanged, pop word order preserved.
REQ-026 status_out=1 exactly when count_out=DEPTH; data_ready=1 exactly when count_out>0.
REQ-027 FIFO pointers wrap modulo DEPTH; words leave in arrival order.

Reset
REQ-028 reset=0 at a rising edge forces IDLE, counter 0, FIFO empty, count_out 0, data_out 0, data_ready 0, status_out 0, abort_out 0, overflow_out 0.
REQ-029 Reset mid-word or with FIFO occupied discards all stored data; no abort_out pulse is generated.
REQ-030 Inputs are ignored on any edge where reset=0.

Structure
REQ-031 Package deserializador_pkg holds the FSM state typedef and the default WIDTH/DEPTH constants.
REQ-032 Storage is a sub-module fifo_sync (parameters WIDTH, DEPTH; push, pop, full, empty, count, head) instantiated once.

Verification
REQ-033 WIDTH=8, MSB_FIRST=0, bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> data_out=8'hA5, data_ready=1 the next cycle, count_out=1.
REQ-034 Same bits, MSB_FIRST=1 -> data_out=8'hA5 reversed = 8'hA5 mirrored 8'hA5->8'hA5 check with bits 1,1,0,0,0,0,0,0 -> data_out=8'hC0 (MSB_FIRST=1) vs 8'h03 (MSB_FIRST=0).
REQ-035 DEPTH=4, five words 8'h11..8'h55 streamed with no ack -> status_out=1 after 4th word, 5th word's bits ignored, overflow_out=1; acks then return 11,22,33,44 in order.
REQ-036 write_in dropped after 3 bits -> abort_out one-cycle pulse, count_out unchanged; next full word 8'h3C received correctly.
REQ-037 count_out=2, ack_in high on the edge completing word 8'h77 -> count_out stays 2, 8'h77 delivered last.
REQ-038 reset=0 asserted mid-word with count_out=3 -> next cycle all outputs 0; subsequent word 8'h5A received correctly.
